usb_word_packer: RTL and testbench

Downstream consumer of the serial synchronizer's output. Each 32-bit word arrives with a one-cycle ready strobe and is buffered in a small FIFO. Words are then split into two 16-bit halves and written, low half first, to the 16-bit synchronous USB bridge FIFO under its full-flag backpressure. Overflow of the internal FIFO is flagged sticky rather than stalling the upstream, which has no backpressure path.

---
 rtl/usb_word_packer_if.sv | 34 +++
 rtl/usb_word_packer.sv | 139 +++++++++++++
 tb/tb_usb_word_packer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_word_packer_if.sv
// rtl/usb_word_packer_if.sv - word input, USB bridge half-word output and status bundle
//
// Purpose: groups the packer's data-path and status signals so the packer and
// its environment connect through a single port.
// Signals:
//   i_data       32         word from the serial synchronizer
//   i_data_ready 1          one-cycle strobe qualifying i_data
//   usb_full     1          USB bridge FIFO cannot take a write this cycle
//   o_usb_data   16         half-word presented to the USB bridge
//   o_usb_wr     1          USB bridge write enable
//   overflow     1          sticky dropped-word flag
//   level        ADDR_W+1   internal FIFO occupancy
// Modports: slave = packer side, master = environment side.
interface usb_word_packer_if #(
  parameter int ADDR_W = 4
);
  logic [31:0]     i_data;
  logic            i_data_ready;
  logic            usb_full;
  logic [15:0]     o_usb_data;
  logic            o_usb_wr;
  logic            overflow;
  logic [ADDR_W:0] level;

  modport slave (
    input  i_data, i_data_ready, usb_full,
    output o_usb_data, o_usb_wr, overflow, level
  );

  modport master (
    output i_data, i_data_ready, usb_full,
    input  o_usb_data, o_usb_wr, overflow, level
  );
endinterface

// File: rtl/usb_word_packer.sv
// rtl/usb_word_packer.sv - buffers 32-bit words and writes them as 16-bit halves to the USB bridge
//
// Purpose: strobed 32-bit words are queued in a DEPTH-entry FIFO, then a
// three-state read FSM moves each word into a hold register and emits its low
// half followed by its high half under the bridge's full-flag backpressure.
// Words arriving while the FIFO is full are dropped and flagged sticky.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  usb_word_packer_if.slave (i_data, i_data_ready, usb_full in;
//        o_usb_data, o_usb_wr, overflow, level out)
module usb_word_packer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_word_packer_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       hold_q;
  logic [15:0]       usb_data_q;
  logic              overflow_q;
  state_t            state_q;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        xfer;
  logic [31:0] head;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign head  = mem[rd_ptr_q];

  // A strobe while full is dropped even if a pop frees a slot this cycle.
  assign push = bus.i_data_ready && !full;

  // usb_full is used in its same-cycle value: this is the only combinational
  // path from an input to an output.
  assign xfer = (state_q != IDLE) && !bus.usb_full;

  // The hold register is refilled from IDLE, or straight after the high half
  // goes out so consecutive words stream without a bubble.
  assign pop = !empty && ((state_q == IDLE) || ((state_q == HIGH) && xfer));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (bus.i_data_ready && full) overflow_q <= 1'b1;
    end
  end

  // Read FSM; o_usb_data is registered alongside the state so it already
  // holds the half belonging to the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      usb_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            hold_q     <= head;
            usb_data_q <= head[15:0];
            state_q    <= LOW;
          end
        end
        LOW: begin
          if (xfer) begin
            usb_data_q <= hold_q[31:16];
            state_q    <= HIGH;
          end
        end
        HIGH: begin
          if (xfer) begin
            if (!empty) begin
              hold_q     <= head;
              usb_data_q <= head[15:0];
              state_q    <= LOW;
            end else begin
              usb_data_q <= '0;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          usb_data_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_usb_data = usb_data_q;
  assign bus.o_usb_wr   = xfer;
  assign bus.overflow   = overflow_q;
  assign bus.level      = count_q;

endmodule

// File: tb/tb_usb_word_packer.sv
// tb/tb_usb_word_packer.sv - self-checking bench for usb_word_packer
module tb_usb_word_packer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_word_packer_if #(.ADDR_W(ADDR_W)) bus ();

  usb_word_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of buffered words plus the word being emitted
  // and which of its halves is next.
  logic [31:0] m_fifo[$];
  logic [31:0] m_hold;
  logic        m_hv;
  logic        m_half;
  logic        m_ovf;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic        s_wr;
  logic [15:0] s_data;

  task automatic model_reset();
    m_fifo.delete();
    m_hold = '0;
    m_hv   = 1'b0;
    m_half = 1'b0;
    m_ovf  = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // One clock cycle: drive after the edge, check mid-cycle, advance model.
  task automatic step(input logic s, input logic [31:0] d, input logic f);
    logic        e_wr;
    logic [15:0] e_data;
    logic        full_pre;
    logic        take;
    @(posedge clk);
    #1;
    bus.i_data_ready = s;
    bus.i_data       = d;
    bus.usb_full     = f;
    @(negedge clk);
    e_wr   = m_hv && !f;
    e_data = !m_hv ? 16'h0000 : (m_half ? m_hold[31:16] : m_hold[15:0]);
    s_wr   = bus.o_usb_wr;
    s_data = bus.o_usb_data;
    chk("wr", 32'(s_wr), 32'(e_wr));
    chk("data", 32'(s_data), 32'(e_data));
    chk("level", 32'(bus.level), 32'(m_fifo.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (s_wr) obs_q.push_back(s_data);
    full_pre = (m_fifo.size() == DEPTH);
    take     = !m_hv || (m_half && e_wr);
    if (e_wr) begin
      if (m_half) begin
        m_hv   = 1'b0;
        m_half = 1'b0;
      end else begin
        m_half = 1'b1;
      end
    end
    if (take && m_fifo.size() > 0) begin
      m_hold = m_fifo.pop_front();
      m_hv   = 1'b1;
      m_half = 1'b0;
    end
    if (s) begin
      if (full_pre) m_ovf = 1'b1;
      else begin
        m_fifo.push_back(d);
        exp_q.push_back(d[15:0]);
        exp_q.push_back(d[31:16]);
      end
    end
  endtask

  task automatic stream_check(input string name);
    int n;
    chk({name, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_half%0d", name, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic        s;
    logic [31:0] d;
    logic        f;
    logic        exp_wr;
    logic [15:0] exp_data;
    logic [4:0]  exp_level;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic s, logic [31:0] d, logic f, logic ew, logic [15:0] ed, logic [4:0] el);
    vec_t v;
    v.s = s; v.d = d; v.f = f; v.exp_wr = ew; v.exp_data = ed; v.exp_level = el;
    return v;
  endfunction

  initial begin
    int gap;
    logic rs;
    logic rf;
    bus.i_data       = '0;
    bus.i_data_ready = 1'b0;
    bus.usb_full     = 1'b0;
    model_reset();

    // Single word, then backpressure on the low half for three cycles.
    tbl.push_back(mk(1, 32'hDEADBEEF, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 32'h0,        0, 1, 16'hBEEF, 0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 16'hDEAD, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 32'h12345678, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 16'h0000, 1));
    tbl.push_back(mk(0, 32'h0,        1, 0, 16'h5678, 0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 16'h5678, 0));
    tbl.push_back(mk(0, 32'h0,        1, 0, 16'h5678, 0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 16'h5678, 0));
    tbl.push_back(mk(0, 32'h0,        0, 1, 16'h1234, 0));
    tbl.push_back(mk(0, 32'h0,        0, 0, 16'h0000, 0));

    #12;
    chk("rst_wr", 32'(bus.o_usb_wr), 0);
    chk("rst_data", 32'(bus.o_usb_data), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    #5 rst = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      bus.i_data_ready = tbl[i].s;
      bus.i_data       = tbl[i].d;
      bus.usb_full     = tbl[i].f;
      @(negedge clk);
      chk($sformatf("vec%0d_wr", i), 32'(bus.o_usb_wr), 32'(tbl[i].exp_wr));
      chk($sformatf("vec%0d_data", i), 32'(bus.o_usb_data), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(tbl[i].exp_level));
      chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 0);
    end

    // Streaming four words two cycles apart.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {16'(i + 1), 16'(i)}, 1'b0);
      step(1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    chk("stream4_len_abs", 32'(obs_q.size()), 8);
    stream_check("stream4");

    // Forty words back to back across the pointer wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, $urandom, 1'b0);
      chk("wrap_level_max", 32'(bus.level <= 1), 1);
      step(1'b0, 32'h0, 1'b0);
      chk("wrap_level_max", 32'(bus.level <= 1), 1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    chk("wrap_len_abs", 32'(obs_q.size()), 80);
    stream_check("wrap");

    // Overflow: hold plus DEPTH words fit, the 18th is dropped.
    for (int i = 1; i <= 18; i++) begin
      step(1'b1, 32'(i), 1'b1);
      step(1'b0, 32'h0, 1'b1);
    end
    chk("ovf_level", 32'(bus.level), 16);
    chk("ovf_flag", 32'(bus.overflow), 1);
    for (int i = 0; i < 40; i++) step(1'b0, 32'h0, 1'b0);
    chk("ovf_halves", 32'(obs_q.size()), 34);
    for (int k = 0; k < 17 && 2 * k + 1 < obs_q.size(); k++) begin
      chk($sformatf("ovf_lo%0d", k + 1), 32'(obs_q[2 * k]), 32'(k + 1));
      chk($sformatf("ovf_hi%0d", k + 1), 32'(obs_q[2 * k + 1]), 0);
    end
    chk("ovf_sticky", 32'(bus.overflow), 1);
    stream_check("ovf");

    // Randomized traffic with bursts of backpressure.
    gap = 10;
    for (int i = 0; i < 800; i++) begin
      rs = (gap >= 2) && ($urandom_range(0, 2) == 0);
      rf = ((i % 200) < 100) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      step(rs, $urandom, rf);
      gap = rs ? 1 : gap + 1;
    end
    for (int i = 0; i < 80; i++) step(1'b0, 32'h0, 1'b0);
    stream_check("random");

    // Reset with five words buffered and the FSM emitting a high half.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hA0000000 + 32'(i), 1'b1);
      step(1'b0, 32'h0, 1'b1);
    end
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("pre_rst_level", 32'(bus.level), 5);
    chk("pre_rst_high", 32'(bus.o_usb_data), 32'h0000A000);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    bus.usb_full = 1'b0;
    #0;
    chk("arst_wr", 32'(bus.o_usb_wr), 0);
    chk("arst_data", 32'(bus.o_usb_data), 0);
    chk("arst_level", 32'(bus.level), 0);
    chk("arst_overflow", 32'(bus.overflow), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("post_rst_idle", 32'(s_wr), 0);
    end
    step(1'b1, 32'hCAFEF00D, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("lat_t1_wr", 32'(s_wr), 0);
    chk("lat_t1_level", 32'(bus.level), 1);
    step(1'b0, 32'h0, 1'b0);
    chk("lat_t2_wr", 32'(s_wr), 1);
    chk("lat_t2_data", 32'(s_data), 32'h0000F00D);
    step(1'b0, 32'h0, 1'b0);
    chk("lat_t3_wr", 32'(s_wr), 1);
    chk("lat_t3_data", 32'(s_data), 32'h0000CAFE);
    step(1'b0, 32'h0, 1'b0);
    chk("lat_t4_wr", 32'(s_wr), 0);
    stream_check("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
